// File: rtl/fp32_to_e4m3_quant_if.sv
// Stream bundle for the FP32 -> E4M3 quantizer.
// The slave side is the quantizer, the master side is whatever feeds it and drains it.
interface fp32_to_e4m3_quant_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_nan;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_nan
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_nan
  );
endinterface

// File: rtl/fp32_to_e4m3_quant.sv
// FP32 -> FP8 E4M3 streaming quantizer, 2-stage valid/ready pipeline.
// S1 classifies the sample and aligns the significand.
// S2 applies round-to-nearest-even, packs the code and holds the registered outputs.
//
// Both target ranges share one datapath. Normal targets use shift 0 and base = e+6.
// Subnormal targets use shift = -6-e and base = 0.
// The packed magnitude is then base*8 + rounded 4-bit significand. Because of this,
// a mantissa carry and a subnormal-to-normal promotion both fall out of the add.
module fp32_to_e4m3_quant #(
  parameter bit SATURATE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  fp32_to_e4m3_quant_if.slave io
);

  typedef struct packed {
    logic       sign;
    logic       is_nan;
    logic       is_inf;
    logic [7:0] base;    // exponent field minus one for normals, 0 for subnormals
    logic [3:0] q;       // kept significand bits: hidden bit plus 3 mantissa bits
    logic       guard;
    logic       sticky;
  } s1_t;

  logic [2:1]  vld_pipe;
  logic        adv1, adv2;

  s1_t         s1_d, s1_q;
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [6:0]  shamt;
  logic [47:0] aligned;

  logic        round_up;
  logic [4:0]  q_rnd;
  logic [11:0] code;
  logic        ovf;
  logic [7:0]  data_d, data_q;
  logic        sat_d, sat_q;
  logic        nan_d, nan_q;

  assign adv2         = !vld_pipe[2] || io.out_ready;
  assign adv1         = !vld_pipe[1] || adv2;
  assign io.in_ready  = adv1;
  assign io.out_valid = vld_pipe[2];
  assign io.out_data  = data_q;
  assign io.out_sat   = sat_q;
  assign io.out_nan   = nan_q;

  // S1 comb: classify and align 1.M so bits 47:44 hold the kept significand.
  // E=0 has no hidden bit and shifts 121, which yields signed zero.
  always_comb begin
    exp_f       = io.in_data[30:23];
    frac        = io.in_data[22:0];
    shamt       = (exp_f >= 8'd121) ? 7'd0 : 7'(8'd121 - exp_f);
    aligned     = {exp_f != 8'd0, frac, 24'b0} >> shamt;
    s1_d.sign   = io.in_data[31];
    s1_d.is_nan = (&exp_f) && (|frac);
    s1_d.is_inf = (&exp_f) && !(|frac);
    s1_d.base   = (exp_f >= 8'd121) ? (exp_f - 8'd121) : 8'd0;
    s1_d.q      = aligned[47:44];
    s1_d.guard  = aligned[43];
    s1_d.sticky = |aligned[42:0];
  end

  // S2 comb: RNE round, pack, then replace specials and overflow.
  // Overflow is any packed magnitude above 0x7E, so the 464 tie still lands on 448.
  always_comb begin
    round_up = s1_q.guard & (s1_q.sticky | s1_q.q[0]);
    q_rnd    = {1'b0, s1_q.q} + {4'b0, round_up};
    code     = {1'b0, s1_q.base, 3'b0} + {7'b0, q_rnd};
    ovf      = code > 12'd126;
    data_d   = {s1_q.sign, code[6:0]};
    sat_d    = 1'b0;
    nan_d    = 1'b0;
    if (s1_q.is_nan) begin
      data_d = {s1_q.sign, 7'h7F};
      nan_d  = 1'b1;
    end else if (s1_q.is_inf || ovf) begin
      data_d = SATURATE ? {s1_q.sign, 7'h7E} : {s1_q.sign, 7'h7F};
      sat_d  = 1'b1;
      nan_d  = !SATURATE;
    end
  end

  // Stage valids advance independently so a stalled S2 still lets S1 fill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= io.in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 payload: load only on a real input transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   s1_q <= '0;
    else if (adv1 && io.in_valid) s1_q <= s1_d;
  end

  // S2 payload: the code and its flags move together, and hold while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= 8'h00;
      sat_q  <= 1'b0;
      nan_q  <= 1'b0;
    end else if (adv2 && vld_pipe[1]) begin
      data_q <= data_d;
      sat_q  <= sat_d;
      nan_q  <= nan_d;
    end
  end

endmodule
